sfx_scheduler: RTL and testbench
================================

// Module: sfx_scheduler
// PURPOSE
//  Time-shares the single-port audio sample ROM between NV sound-effect voices (music, bomb, blast, ...).
//  On every sample tick: fetches one sample per active voice, mixes with saturation, hands the mix to the codec write port.
//  Sits between the ROM / sample-rate divider and the audio_codec writedata/write handshake.
// PARAMETERS
//  NV        4    number of voices (requesters)
//  ADDR_W    14   ROM address width
//  DW        24   sample width, signed two's complement
//  ROM_LAT   2    cycles from rom_addr change to valid rom_q
// PORTS
//  CLOCK_50     in   1        system clock
//  reset        in   1        synchronous, active-high
//  sample_tick  in   1        1-cycle pulse per output sample (~48.8 kHz)
//  trig         in   NV       1-cycle start/restart pulse per voice
//  rom_addr     out  ADDR_W   ROM address
//  rom_q        in   DW       ROM data, ROM_LAT cycles after rom_addr
//  write_ready  in   1        codec can accept a sample
//  write        out  1        1-cycle write strobe to codec
//  writedata    out  DW       mixed sample (drive both L and R)
//  active       out  NV       voice currently playing
//  overrun      out  1        1-cycle pulse: tick arrived while frame busy
// BEHAVIOUR
//  Reset: rom_addr=0, write=0, writedata=0, active=0, overrun=0, pending=0, FSM=IDLE.
//  trig[i] ORs into pending[i] in any state. pending is applied only in IDLE on sample_tick:
//   active[i]<=1, ptr[i]<=CLIP_BASE[i], pending cleared.
//   Retrigger restarts from base; trigger in same frame as completion -> trigger wins.
//  FSM: IDLE -tick-> SCAN (acc=0, v=0).
//   SCAN: if v==NV -> SAT. Else if active[v] -> rom_addr=ptr[v], go WAIT. Else v++.
//   WAIT: hold ROM_LAT cycles -> ACC.
//   ACC: acc+=sext(rom_q); on ptr[v]==CLIP_BASE[v]+CLIP_LEN[v]-1 clear active[v], else ptr[v]++; v++, -> SCAN.
//   SAT: acc (ACC_W=DW+clog2(NV)+1) clamps to [-2^(DW-1), 2^(DW-1)-1] into writedata -> OUT.
//   OUT: when write_ready, write=1 for exactly one cycle -> IDLE. Waits indefinitely while write_ready=0.
//  Tick to OUT entry: <= NV*(ROM_LAT+2)+2 cycles.
//  sample_tick outside IDLE: tick dropped, overrun pulses next cycle, current frame unaffected.
//  No active voices -> frame still produces writedata=0 (codec never starves).
//  Reset mid-frame: immediate return to reset values; pending triggers lost.
// CONFIGURATION
//  SFX_LOOP_EN defined: voice 0 wraps ptr to CLIP_BASE[0] at end of clip and stays active (background music).
//  SFX_LOOP_EN undefined: voice 0 stops at end of clip like every other voice.
// STRUCTURE
//  Package sfx_pkg holds:
//   CLIP_BASE/CLIP_LEN tables: 0/8192, 8192/2048, 10240/4096, 14336/2048.
//   FSM state enum {IDLE,SCAN,WAIT,ACC,SAT,OUT}; ACC_W.
//  Sub-module sfx_sat: combinational ACC_W->DW saturating clamp.
//  Per-voice ptr/active registers stay in sfx_scheduler.
// TESTING
//  1. Reset, no trig, 3 ticks -> 3 writes, writedata=0 each, active=0.
//  2. ROM model q=addr; trig[1]:
//     - frames give 8192, 8193, ...
//     - after 2048 ticks active[1]=0, next writedata=0.
//  3. trig[1]+trig[2], ROM const 0x700000 -> writedata=0x7FFFFF; const 0x900000 (neg) -> 0x800000.
//  4. write_ready=0 for 2000 cycles, tick every 1024 -> overrun pulses once, exactly one write after ready rises.
//  5. Retrigger voice 1 at ptr 8300 -> next frame fetches addr 8192, active[1] stays 1.
//  6. trig[0], run 8192 ticks:
//     - SFX_LOOP_EN: next fetch addr 0, active[0]=1.
//     - otherwise: active[0]=0.

Source files
------------

// File: rtl/sfx_pkg.sv
// rtl/sfx_pkg.sv - shared sizes, clip table and state encoding for the SFX scheduler
package sfx_pkg;

    localparam int SFX_NV      = 4;
    localparam int SFX_ADDR_W  = 14;
    localparam int SFX_DW      = 24;
    localparam int SFX_ROM_LAT = 2;

    // Three guard bits: two for the NV-way sum, one for the sign
    localparam int ACC_W = SFX_DW + $clog2(SFX_NV) + 1;

    localparam int CLIP_BASE [SFX_NV] = '{0, 8192, 10240, 14336};
    localparam int CLIP_LEN  [SFX_NV] = '{8192, 2048, 4096, 2048};

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_SCAN = 3'd1;
    localparam logic [2:0] ST_WAIT = 3'd2;
    localparam logic [2:0] ST_ACC  = 3'd3;
    localparam logic [2:0] ST_SAT  = 3'd4;
    localparam logic [2:0] ST_OUT  = 3'd5;

    function automatic int clip_last(input int v);
        return CLIP_BASE[v] + CLIP_LEN[v] - 1;
    endfunction

endpackage

// File: rtl/sfx_sat.sv
// rtl/sfx_sat.sv - combinational saturating clamp from the wide mix accumulator to the sample width
module sfx_sat #(
    parameter int IN_W  = 27,
    parameter int OUT_W = 24
) (
    input  logic [IN_W-1:0]  din,
    output logic [OUT_W-1:0] dout
);

    logic [IN_W-OUT_W:0] hi;

    // In range exactly when every bit above the output sign bit copies it
    always_comb begin
        hi = din[IN_W-1:OUT_W-1];
        if (hi == '0 || hi == '1) begin
            dout = din[OUT_W-1:0];
        end else if (din[IN_W-1]) begin
            dout = {1'b1, {(OUT_W-1){1'b0}}};
        end else begin
            dout = {1'b0, {(OUT_W-1){1'b1}}};
        end
    end

endmodule

// File: rtl/sfx_scheduler.sv
// rtl/sfx_scheduler.sv - time-shares the sample ROM across NV voices, mixes and feeds the codec
// Define SFX_LOOP_EN to make voice 0 loop its clip forever (background music).
module sfx_scheduler
    import sfx_pkg::*;
#(
    parameter int NV      = SFX_NV,
    parameter int ADDR_W  = SFX_ADDR_W,
    parameter int DW      = SFX_DW,
    parameter int ROM_LAT = SFX_ROM_LAT
) (
    input  logic              CLOCK_50,
    input  logic              reset,
    input  logic              sample_tick,
    input  logic [NV-1:0]     trig,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [DW-1:0]     rom_q,
    input  logic              write_ready,
    output logic              write,
    output logic [DW-1:0]     writedata,
    output logic [NV-1:0]     active,
    output logic              overrun
);

    localparam int VW = $clog2(NV + 1);
    localparam int IW = $clog2(NV);
    localparam int CW = $clog2(ROM_LAT + 1);

    logic [2:0]        state_q, state_d;
    logic [VW-1:0]     v_q, v_d;
    logic [CW-1:0]     wait_q, wait_d;
    logic [ACC_W-1:0]  acc_q, acc_d;
    logic [ADDR_W-1:0] ptr_q [NV];
    logic [ADDR_W-1:0] ptr_d [NV];
    logic [NV-1:0]     active_q, active_d;
    logic [NV-1:0]     pending_q, pending_d;
    logic [ADDR_W-1:0] rom_addr_q, rom_addr_d;
    logic              write_q, write_d;
    logic [DW-1:0]     writedata_q, writedata_d;
    logic              overrun_q, overrun_d;
    logic [DW-1:0]     sat_out;
    logic [IW-1:0]     vi;

    assign vi = v_q[IW-1:0];

    sfx_sat #(.IN_W(ACC_W), .OUT_W(DW)) u_sat (
        .din  (acc_q),
        .dout (sat_out)
    );

    always_comb begin
        state_d     = state_q;
        v_d         = v_q;
        wait_d      = wait_q;
        acc_d       = acc_q;
        ptr_d       = ptr_q;
        active_d    = active_q;
        pending_d   = pending_q | trig;
        rom_addr_d  = rom_addr_q;
        write_d     = 1'b0;
        writedata_d = writedata_q;
        overrun_d   = sample_tick && (state_q != ST_IDLE);
        case (state_q)
            ST_IDLE: begin
                if (sample_tick) begin
                    for (int i = 0; i < NV; i++) begin
                        if (pending_q[i]) begin
                            active_d[i] = 1'b1;
                            ptr_d[i]    = ADDR_W'(CLIP_BASE[i]);
                        end
                    end
                    // A trigger landing on the tick itself is kept for the next frame
                    pending_d = trig;
                    acc_d     = '0;
                    v_d       = '0;
                    state_d   = ST_SCAN;
                end
            end
            ST_SCAN: begin
                if (v_q == VW'(NV)) begin
                    state_d = ST_SAT;
                end else if (active_q[vi]) begin
                    rom_addr_d = ptr_q[vi];
                    wait_d     = '0;
                    state_d    = ST_WAIT;
                end else begin
                    v_d = v_q + VW'(1);
                end
            end
            ST_WAIT: begin
                if (wait_q == CW'(ROM_LAT - 1)) begin
                    state_d = ST_ACC;
                end else begin
                    wait_d = wait_q + CW'(1);
                end
            end
            ST_ACC: begin
                acc_d = acc_q + {{(ACC_W - DW){rom_q[DW-1]}}, rom_q};
                if (ptr_q[vi] == ADDR_W'(clip_last(int'(vi)))) begin
`ifdef SFX_LOOP_EN
                    if (vi == '0) begin
                        ptr_d[vi] = ADDR_W'(CLIP_BASE[0]);
                    end else begin
                        active_d[vi] = 1'b0;
                    end
`else
                    active_d[vi] = 1'b0;
`endif
                end else begin
                    ptr_d[vi] = ptr_q[vi] + ADDR_W'(1);
                end
                v_d     = v_q + VW'(1);
                state_d = ST_SCAN;
            end
            ST_SAT: begin
                writedata_d = sat_out;
                state_d     = ST_OUT;
            end
            ST_OUT: begin
                if (write_ready) begin
                    write_d = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            v_q         <= '0;
            wait_q      <= '0;
            acc_q       <= '0;
            for (int i = 0; i < NV; i++) ptr_q[i] <= '0;
            active_q    <= '0;
            pending_q   <= '0;
            rom_addr_q  <= '0;
            write_q     <= 1'b0;
            writedata_q <= '0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            v_q         <= v_d;
            wait_q      <= wait_d;
            acc_q       <= acc_d;
            ptr_q       <= ptr_d;
            active_q    <= active_d;
            pending_q   <= pending_d;
            rom_addr_q  <= rom_addr_d;
            write_q     <= write_d;
            writedata_q <= writedata_d;
            overrun_q   <= overrun_d;
        end
    end

    assign rom_addr  = rom_addr_q;
    assign write     = write_q;
    assign writedata = writedata_q;
    assign active    = active_q;
    assign overrun   = overrun_q;

endmodule

// File: tb/tb_sfx_scheduler.sv
// tb/tb_sfx_scheduler.sv - self-checking bench for sfx_scheduler, frame-level model (honours SFX_LOOP_EN)
`timescale 1ns/1ps
module tb_sfx_scheduler;

    localparam int NV  = 4;
    localparam int AW  = 14;
    localparam int DW  = 24;
    localparam int LAT = 2;
    localparam int BASE [4] = '{0, 8192, 10240, 14336};
    localparam int LEN  [4] = '{8192, 2048, 4096, 2048};
    localparam int MAX_LAT = NV * (LAT + 2) + 3;
`ifdef SFX_LOOP_EN
    localparam bit LOOP0 = 1'b1;
`else
    localparam bit LOOP0 = 1'b0;
`endif

    logic          CLOCK_50 = 1'b0;
    logic          reset = 1'b1;
    logic          sample_tick = 1'b0;
    logic          write_ready = 1'b1;
    logic [NV-1:0] trig = '0;
    logic [AW-1:0] rom_addr;
    logic [DW-1:0] rom_q;
    logic          write;
    logic [DW-1:0] writedata;
    logic [NV-1:0] active;
    logic          overrun;

    int            rom_mode = 0;
    logic [DW-1:0] rom_const = '0;
    logic [DW-1:0] rom_p1 = '0, rom_p2 = '0;
    int            n_cmp = 0, n_bad = 0;

    always #10 CLOCK_50 = ~CLOCK_50;

    sfx_scheduler dut (
        .CLOCK_50    (CLOCK_50),
        .reset       (reset),
        .sample_tick (sample_tick),
        .trig        (trig),
        .rom_addr    (rom_addr),
        .rom_q       (rom_q),
        .write_ready (write_ready),
        .write       (write),
        .writedata   (writedata),
        .active      (active),
        .overrun     (overrun)
    );

    function automatic logic [DW-1:0] rom_val(input logic [AW-1:0] a);
        return (rom_mode == 0) ? DW'(a) : rom_const;
    endfunction

    always @(posedge CLOCK_50) begin
        rom_p1 <= rom_val(rom_addr);
        rom_p2 <= rom_p1;
    end
    assign rom_q = rom_p2;

    function automatic logic [DW-1:0] sat24(input int s);
        if (s > 8388607) return 24'h7FFFFF;
        if (s < -8388608) return 24'h800000;
        return s[DW-1:0];
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Frame-level model: a whole frame is evaluated at the moment its tick is accepted
    logic [NV-1:0] m_active = '0, m_pending = '0;
    int            m_ptr [NV];
    bit            m_busy = 0, m_ovr = 0, m_valid = 0, last_ready = 0, wr_now = 0, idle = 0;
    int            m_age = 0, m_stall = 0, sum = 0;
    logic [DW-1:0] exp_q [$];

    always @(posedge CLOCK_50) begin
        if (reset) begin
            m_active = '0; m_pending = '0; m_busy = 0; m_ovr = 0; m_valid = 1;
            for (int i = 0; i < NV; i++) m_ptr[i] = 0;
            exp_q.delete();
        end else begin
            idle  = !m_busy || wr_now;
            m_ovr = 0;
            if (wr_now) m_busy = 0;
            if (m_busy) begin
                m_age++;
                if (!write_ready) m_stall++;
            end
            if (sample_tick && idle) begin
                for (int i = 0; i < NV; i++) begin
                    if (m_pending[i]) begin
                        m_active[i] = 1'b1;
                        m_ptr[i] = BASE[i];
                    end
                end
                m_pending = trig;
                sum = 0;
                for (int i = 0; i < NV; i++) begin
                    if (m_active[i]) begin
                        sum += $signed(rom_val(AW'(m_ptr[i])));
                        if (m_ptr[i] == BASE[i] + LEN[i] - 1) begin
                            if (i == 0 && LOOP0) m_ptr[i] = BASE[i];
                            else m_active[i] = 1'b0;
                        end else begin
                            m_ptr[i]++;
                        end
                    end
                end
                exp_q.push_back(sat24(sum));
                m_busy = 1; m_age = 0; m_stall = 0;
            end else begin
                if (sample_tick) m_ovr = 1;
                m_pending |= trig;
            end
        end
        last_ready = write_ready;
    end

    always @(negedge CLOCK_50) begin
        wr_now = write;
        if (m_valid && !reset) begin
            chk("overrun", overrun, m_ovr);
            if (write) begin
                chk("frames_outstanding", exp_q.size(), 1);
                chk("ready_before_write", last_ready, 1);
                chk("active_at_write", active, m_active);
                chk("latency_in_bound", (m_age - m_stall) <= MAX_LAT, 1);
                if (exp_q.size() > 0) chk("writedata", writedata, exp_q.pop_front());
            end
        end
    end

    task automatic pulse_trig(input logic [NV-1:0] m);
        trig = m;
        @(negedge CLOCK_50);
        trig = '0;
    endtask

    task automatic frame(output logic [DW-1:0] wd, output logic [NV-1:0] act);
        bit seen = 0;
        sample_tick = 1'b1;
        @(negedge CLOCK_50);
        sample_tick = 1'b0;
        for (int i = 0; i < 200 && !seen; i++) begin
            if (write) seen = 1;
            else @(negedge CLOCK_50);
        end
        chk("frame_done", seen, 1);
        wd  = writedata;
        act = active;
    endtask

    task automatic chk_reset_values();
        chk("rst_rom_addr", rom_addr, 0);
        chk("rst_write", write, 0);
        chk("rst_writedata", writedata, 0);
        chk("rst_active", active, 0);
        chk("rst_overrun", overrun, 0);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [DW-1:0] wd;
        logic [NV-1:0] act;
        int n_ovr, n_wr;

        reset = 1'b1;
        repeat (3) @(negedge CLOCK_50);
        chk_reset_values();
        reset = 1'b0;

        for (int k = 0; k < 3; k++) begin
            frame(wd, act);
            chk("silent_wd", wd, 0);
            chk("silent_active", act, 0);
        end

        rom_mode = 1;
        rom_const = 24'h700000;
        pulse_trig(4'b0110);
        frame(wd, act);
        chk("sat_pos", wd, 24'h7FFFFF);
        chk("sat_pos_active", act, 4'b0110);
        rom_const = 24'h900000;
        frame(wd, act);
        chk("sat_neg", wd, 24'h800000);

        sample_tick = 1'b1;
        @(negedge CLOCK_50);
        sample_tick = 1'b0;
        pulse_trig(4'b1000);
        repeat (3) @(negedge CLOCK_50);
        reset = 1'b1;
        @(negedge CLOCK_50);
        chk_reset_values();
        reset = 1'b0;
        frame(wd, act);
        chk("lost_pending_wd", wd, 0);
        chk("lost_pending_active", act, 0);

        rom_mode = 0;
        pulse_trig(4'b0010);
        for (int k = 0; k < 108; k++) begin
            frame(wd, act);
            if (k == 0) chk("v1_first", wd, 8192);
            if (k == 1) chk("v1_second", wd, 8193);
        end
        pulse_trig(4'b0010);
        frame(wd, act);
        chk("retrig_wd", wd, 8192);
        chk("retrig_active", act[1], 1);

        n_ovr = 0;
        n_wr = 0;
        for (int c = 0; c < 2100; c++) begin
            sample_tick = (c == 0 || c == 1024);
            write_ready = (c >= 2000);
            @(negedge CLOCK_50);
            if (overrun) n_ovr++;
            if (write) n_wr++;
        end
        sample_tick = 1'b0;
        write_ready = 1'b1;
        chk("stall_overruns", n_ovr, 1);
        chk("stall_writes", n_wr, 1);
        frame(wd, act);
        chk("after_stall_wd", wd, 8194);

        reset = 1'b1;
        repeat (2) @(negedge CLOCK_50);
        reset = 1'b0;
        pulse_trig(4'b0011);
        for (int f = 0; f < 8194; f++) begin
            frame(wd, act);
            if (f == 0)    chk("mix_first", wd, 8192);
            if (f == 2047) chk("v1_last_wd", wd, 12286);
            if (f == 2047) chk("v1_done_active", act, 4'b0001);
            if (f == 2048) chk("v0_alone_wd", wd, 2048);
            if (f == 8191) chk("v0_last_wd", wd, 8191);
            if (f == 8191) chk("v0_end_active", act, {3'b000, LOOP0});
            if (f == 8192) chk("v0_wrap_wd", wd, 0);
            if (f == 8192) chk("v0_wrap_active", act, {3'b000, LOOP0});
            if (f == 8193) chk("v0_wrap_next_wd", wd, {23'd0, LOOP0});
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
